// File: rtl/wfm_uart_tx.sv
// Waveform-to-UART serializer: streams captured multi-channel samples, sample indices and a wave_num trailer.
// Define WFM_UART_CHECKSUM_EN to append an XOR checksum byte after the trailer.
module wfm_uart_tx #(
  parameter int SAMPLE_W     = 14,
  parameter int DEPTH        = 2000,
  parameter int NUM_CH       = 1,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [15:0]         wave_num,
  input  logic                abort,
  output logic                rd_en,
  output logic [15:0]         rd_addr,
  output logic [1:0]          rd_ch,
  input  logic [SAMPLE_W-1:0] rd_data,
  output logic                tx,
  output logic                busy,
  output logic                done
);

  localparam int FW = 8 + STOP_BITS;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TICK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    BITS_LAST = 4'(FW);
  localparam logic [1:0]    CH_LAST   = 2'(NUM_CH - 1);
  localparam logic [15:0]   ADDR_LAST = 16'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CAPTURE, S_SHIFT} state_t;
  typedef enum logic [2:0] {B_SHI, B_SLO, B_IHI, B_ILO, B_WHI, B_WLO, B_CHK} kind_t;

  state_t          state_q, state_d;
  kind_t           kind_q, kind_d;
  logic [7:0]      hold_q, hold_d;
  logic [15:0]     wave_q, wave_d;
  logic [FW-1:0]   frm_q, frm_d;
  logic [CW-1:0]   tick_q, tick_d;
  logic [3:0]      bit_q, bit_d;
  logic            abort_q, abort_d;
  logic            rd_en_q, rd_en_d;
  logic [15:0]     rd_addr_q, rd_addr_d;
  logic [1:0]      rd_ch_q, rd_ch_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef WFM_UART_CHECKSUM_EN
  logic [7:0]      chk_q, chk_d;
`endif

  logic        ld, go_fetch, finish, quit, abort_pend;
  logic [7:0]  ld_byte;
  kind_t       ld_kind;
  logic [15:0] samp, idx;

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    hold_d    = hold_q;
    wave_d    = wave_q;
    frm_d     = frm_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    abort_d   = abort_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_ch_d   = rd_ch_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef WFM_UART_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    ld         = 1'b0;
    go_fetch   = 1'b0;
    finish     = 1'b0;
    quit       = 1'b0;
    ld_byte    = 8'h00;
    ld_kind    = kind_q;
    samp       = 16'(rd_data);
    idx        = rd_addr_q + 16'd1;
    abort_pend = abort_q | abort;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          wave_d    = wave_num;
          rd_addr_d = 16'd0;
          rd_ch_d   = 2'd0;
          busy_d    = 1'b1;
          abort_d   = 1'b0;
          rd_en_d   = 1'b1;
          state_d   = S_FETCH;
`ifdef WFM_UART_CHECKSUM_EN
          chk_d     = 8'h00;
`endif
        end
      end
      S_FETCH: begin
        abort_d = abort_pend;
        if (abort_pend) quit = 1'b1;
        else            state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort_pend) begin
          quit = 1'b1;
        end else begin
          hold_d  = samp[7:0];
          ld      = 1'b1;
          ld_byte = samp[15:8];
          ld_kind = B_SHI;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        abort_d = abort_pend;
        if (tick_q != '0) begin
          tick_d = tick_q - 1'b1;
        end else if (bit_q != 4'd0) begin
          bit_d  = bit_q - 4'd1;
          tx_d   = frm_q[0];
          frm_d  = {1'b1, frm_q[FW-1:1]};
          tick_d = TICK_LAST;
        end else if (abort_pend) begin
          quit = 1'b1;
        end else begin
          // last stop bit just ended: pick the next byte of the frame
          case (kind_q)
            B_SHI: begin ld = 1'b1; ld_byte = hold_q; ld_kind = B_SLO; end
            B_SLO: begin
              if (rd_ch_q == CH_LAST) begin
                ld = 1'b1; ld_byte = idx[15:8]; ld_kind = B_IHI;
              end else begin
                rd_ch_d  = rd_ch_q + 2'd1;
                go_fetch = 1'b1;
              end
            end
            B_IHI: begin ld = 1'b1; ld_byte = idx[7:0]; ld_kind = B_ILO; end
            B_ILO: begin
              if (rd_addr_q == ADDR_LAST) begin
                ld = 1'b1; ld_byte = wave_q[15:8]; ld_kind = B_WHI;
              end else begin
                rd_addr_d = idx;
                rd_ch_d   = 2'd0;
                go_fetch  = 1'b1;
              end
            end
            B_WHI: begin ld = 1'b1; ld_byte = wave_q[7:0]; ld_kind = B_WLO; end
            B_WLO: begin
`ifdef WFM_UART_CHECKSUM_EN
              ld = 1'b1; ld_byte = chk_q; ld_kind = B_CHK;
`else
              finish = 1'b1;
`endif
            end
            default: finish = 1'b1;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_fetch) begin
      state_d = S_FETCH;
      rd_en_d = 1'b1;
      tx_d    = 1'b1;
    end
    if (finish || quit) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      tx_d    = 1'b1;
      abort_d = 1'b0;
      done_d  = finish;
    end
    if (ld) begin
      tx_d   = 1'b0;
      frm_d  = {{STOP_BITS{1'b1}}, ld_byte};
      tick_d = TICK_LAST;
      bit_d  = BITS_LAST;
      kind_d = ld_kind;
`ifdef WFM_UART_CHECKSUM_EN
      chk_d  = chk_q ^ ld_byte;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      kind_q    <= B_SHI;
      hold_q    <= 8'h00;
      wave_q    <= 16'h0000;
      frm_q     <= '1;
      tick_q    <= '0;
      bit_q     <= 4'd0;
      abort_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= 16'd0;
      rd_ch_q   <= 2'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef WFM_UART_CHECKSUM_EN
      chk_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      hold_q    <= hold_d;
      wave_q    <= wave_d;
      frm_q     <= frm_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      abort_q   <= abort_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_ch_q   <= rd_ch_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef WFM_UART_CHECKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign rd_ch   = rd_ch_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_wfm_uart_tx.sv
// Bench for wfm_uart_tx: a one-channel and a two-channel instance, a UART-decoding monitor per instance
// checked against a frame model held in expected-byte queues.
module tb_wfm_uart_tx;
  localparam int SW     = 14;
  localparam int DEPTH  = 2;
  localparam int CPB    = 4;
  localparam int STOP   = 3;
  localparam int BYTE_T = (9 + STOP) * CPB;
`ifdef WFM_UART_CHECKSUM_EN
  localparam int NCHK = 1;
`else
  localparam int NCHK = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start0 = 1'b0, start1 = 1'b0;
  logic [15:0]   wave0 = 16'h0, wave1 = 16'h0;
  logic          abort0 = 1'b0, abort1 = 1'b0;
  logic          rd_en0, rd_en1;
  logic [15:0]   rd_addr0, rd_addr1;
  logic [1:0]    rd_ch0, rd_ch1;
  logic [SW-1:0] rd_data0 = '0, rd_data1 = '0;
  logic          tx0, tx1, busy0, busy1, done0, done1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dcnt0 = 0, dcnt1 = 0;
  logic [15:0] ram [2][4][2];
  logic [7:0]  exp_q0[$];
  logic [7:0]  exp_q1[$];

  wfm_uart_tx #(.SAMPLE_W(SW), .DEPTH(DEPTH), .NUM_CH(1), .CLKS_PER_BIT(CPB), .STOP_BITS(STOP)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .wave_num(wave0), .abort(abort0),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_ch(rd_ch0), .rd_data(rd_data0),
    .tx(tx0), .busy(busy0), .done(done0));

  wfm_uart_tx #(.SAMPLE_W(SW), .DEPTH(DEPTH), .NUM_CH(2), .CLKS_PER_BIT(CPB), .STOP_BITS(STOP)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .wave_num(wave1), .abort(abort1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_ch(rd_ch1), .rd_data(rd_data1),
    .tx(tx1), .busy(busy1), .done(done1));

  always @(posedge clk) cyc <= cyc + 1;

  // sample RAMs: data valid only in the cycle after rd_en, garbage otherwise
  always @(posedge clk) begin
    rd_data0 <= (rd_en0 && rd_addr0 < 16'(DEPTH)) ? ram[0][rd_ch0][rd_addr0[0]][SW-1:0] : 14'h1555;
    rd_data1 <= (rd_en1 && rd_addr1 < 16'(DEPTH)) ? ram[1][rd_ch1][rd_addr1[0]][SW-1:0] : 14'h1555;
  end

  always @(negedge clk) begin
    if (done0) dcnt0 = dcnt0 + 1;
    if (done1) dcnt1 = dcnt1 + 1;
  end

  function automatic logic f_tx(input int i);   return (i == 0) ? tx0 : tx1;       endfunction
  function automatic logic f_busy(input int i); return (i == 0) ? busy0 : busy1;   endfunction
  function automatic logic f_done(input int i); return (i == 0) ? done0 : done1;   endfunction
  function automatic logic f_rden(input int i); return (i == 0) ? rd_en0 : rd_en1; endfunction

  function automatic int flen(input int inst);
    int nch = inst + 1;
    return (DEPTH * (2 * nch + 2) + 2 + NCHK) * BYTE_T + 2 * DEPTH * nch;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: channel bytes per sample, then index s+1, then trailer and optional XOR.
  task automatic model_push(input int inst, input logic [15:0] wn, input int nmax);
    logic [7:0]  b[$];
    logic [7:0]  x;
    logic [15:0] v, idx;
    for (int s = 0; s < DEPTH; s++) begin
      for (int c = 0; c <= inst; c++) begin
        v = ram[inst][c][s] & 16'h3FFF;
        b.push_back(v[15:8]);
        b.push_back(v[7:0]);
      end
      idx = 16'((s + 1) % 65536);
      b.push_back(idx[15:8]);
      b.push_back(idx[7:0]);
    end
    b.push_back(wn[15:8]);
    b.push_back(wn[7:0]);
`ifdef WFM_UART_CHECKSUM_EN
    x = 8'h00;
    foreach (b[i]) x = x ^ b[i];
    b.push_back(x);
`else
    x = 8'h00;
`endif
    for (int i = 0; i < b.size() && i < nmax; i++) begin
      if (inst == 0) exp_q0.push_back(b[i]);
      else           exp_q1.push_back(b[i]);
    end
  endtask

  task automatic mon(input int inst);
    logic [7:0] d, e;
    logic       frame_ok, lost, empty;
    forever begin
      @(negedge clk);
      if (rst_n && !f_tx(inst)) begin
        d = 8'h00; frame_ok = 1'b1; lost = 1'b0;
        for (int k = 0; k < 9 + STOP && !lost; k++) begin
          for (int j = 0; j < ((k == 0) ? CPB / 2 : CPB) && !lost; j++) begin
            @(negedge clk);
            if (!rst_n) lost = 1'b1;
          end
          if (!lost) begin
            if (k == 0) begin
              if (f_tx(inst)) frame_ok = 1'b0;
            end else if (k <= 8) begin
              d = {f_tx(inst), d[7:1]};
            end else if (!f_tx(inst)) begin
              frame_ok = 1'b0;
            end
          end
        end
        if (!lost) begin
          checks++;
          empty = (inst == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
          if (empty) begin
            errors++;
            $display("FAIL byte inst%0d: got %02h, expected no byte (t=%0t)", inst, d, $time);
          end else begin
            e = (inst == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (d !== e || !frame_ok) begin
              errors++;
              $display("FAIL byte inst%0d: got %02h framing_ok=%0d, expected %02h framing_ok=1 (t=%0t)",
                       inst, d, frame_ok, e, $time);
            end
          end
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  // Called on a negedge; returns on the negedge after the accepting edge with e0 = that edge's count.
  task automatic do_start(input int inst, input logic [15:0] wn, output int e0);
    if (inst == 0) begin start0 = 1'b1; wave0 = wn; end
    else           begin start1 = 1'b1; wave1 = wn; end
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    if (inst == 0) wave0 = ~wn; else wave1 = ~wn;
    e0 = cyc;
  endtask

  task automatic check_latency(input int inst);
    chk("rd_en_after_start", int'(f_rden(inst)), 1);
    chk("tx_fetch_idle", int'(f_tx(inst)), 1);
    @(negedge clk);
    chk("rd_en_one_cycle", int'(f_rden(inst)), 0);
    chk("tx_capture_idle", int'(f_tx(inst)), 1);
    @(negedge clk);
    chk("first_start_bit", int'(f_tx(inst)), 0);
  endtask

  task automatic wait_done(input int inst, input int e0, input int explen);
    int seen = 0;
    for (int i = 0; i < explen + 100 && seen == 0; i++) begin
      @(negedge clk);
      if (f_done(inst)) seen = 1;
    end
    chk("done_seen", seen, 1);
    if (seen == 1) begin
      chk("done_time", cyc - e0, explen);
      chk("busy_at_done", int'(f_busy(inst)), 0);
    end
  endtask

  initial begin
    int e0, d0, seen, gap;
    logic [15:0] wn;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 4; c++)
        for (int a = 0; a < 2; a++) ram[i][c][a] = 16'($urandom_range(0, 16383));
    ram[0][0][0] = 16'h2ABC; ram[0][0][1] = 16'h0005;
    ram[1][0][0] = 16'h2ABC; ram[1][0][1] = 16'h0005;
    ram[1][1][0] = 16'h0100; ram[1][1][1] = 16'h3FFF;

    repeat (3) @(negedge clk);
    chk("rst_tx0", int'(tx0), 1);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_rd_en0", int'(rd_en0), 0);
    chk("rst_rd_addr0", int'(rd_addr0), 0);
    chk("rst_rd_ch0", int'(rd_ch0), 0);
    chk("rst_tx1", int'(tx1), 1);
    chk("rst_busy1", int'(busy1), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single channel, known contents
    model_push(0, 16'h1234, 1000);
    do_start(0, 16'h1234, e0);
    check_latency(0);
    wait_done(0, e0, flen(0));
    @(negedge clk);
    chk("done_one_cycle", int'(done0), 0);

    // two channels, known contents
    model_push(1, 16'hA55A, 1000);
    do_start(1, 16'hA55A, e0);
    check_latency(1);
    wait_done(1, e0, flen(1));

    // abort during bit 3 of the second byte
    @(negedge clk);
    d0 = dcnt0;
    model_push(0, 16'hBEEF, 2);
    do_start(0, 16'hBEEF, e0);
    check_latency(0);
    while (cyc < e0 + 2 + BYTE_T + 3 * CPB) @(negedge clk);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      @(negedge clk);
      if (!busy0) seen = 1;
    end
    chk("abort_busy_fall_seen", seen, 1);
    chk("abort_busy_fall_time", cyc - e0, 2 + 2 * BYTE_T);
    repeat (20) @(negedge clk);
    chk("abort_tx_idle", int'(tx0), 1);
    chk("abort_no_done", dcnt0 - d0, 0);
    chk("abort_bytes_drained", exp_q0.size(), 0);
    model_push(0, 16'h0F0F, 1000);
    do_start(0, 16'h0F0F, e0);
    check_latency(0);
    wait_done(0, e0, flen(0));

    // reset in the middle of a data bit, then restart one cycle after release
    @(negedge clk);
    model_push(0, 16'h7777, 1000);
    do_start(0, 16'h7777, e0);
    check_latency(0);
    while (cyc < e0 + 23) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midbyte_rst_tx", int'(tx0), 1);
    chk("midbyte_rst_busy", int'(busy0), 0);
    exp_q0.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_push(0, 16'h4321, 1000);
    do_start(0, 16'h4321, e0);
    check_latency(0);
    wait_done(0, e0, flen(0));

    // start while busy is ignored
    @(negedge clk);
    d0 = dcnt0;
    model_push(0, 16'hC3C3, 1000);
    do_start(0, 16'hC3C3, e0);
    check_latency(0);
    repeat (100) @(negedge clk);
    start0 = 1'b1; wave0 = 16'hFFFF;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0, e0, flen(0));
    repeat (flen(0) + 20) @(negedge clk);
    chk("busy_start_one_done", dcnt0 - d0, 1);
    chk("busy_start_idle", int'(busy0), 0);

    // random frames, sometimes restarted on the very cycle done is high
    for (int inst = 0; inst < 2; inst++) begin
      @(negedge clk);
      for (int n = 0; n < 4; n++) begin
        for (int c = 0; c <= inst; c++)
          for (int a = 0; a < DEPTH; a++) ram[inst][c][a] = 16'($urandom_range(0, 16383));
        wn = 16'($urandom);
        gap = (n == 0) ? 0 : $urandom_range(0, 3);
        repeat (gap) @(negedge clk);
        model_push(inst, wn, 1000);
        do_start(inst, wn, e0);
        check_latency(inst);
        wait_done(inst, e0, flen(inst));
      end
    end

    repeat (20) @(negedge clk);
    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
